// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

   // One decoded key event as stored in the event FIFO.
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   typedef enum logic {
      RX_IDLE,
      RX_RECV
   } ps2_rx_state_e;

endpackage

// File: rtl/ps2_kbd_rx_fifo.sv
// Show-ahead synchronous FIFO of key events. When empty, the head output
// holds the most recently popped entry (zero after reset).
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  ps2_event_t       data_i,
   input  logic             pop_i,
   output ps2_event_t       data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   ps2_event_t       mem_q [DEPTH];
   ps2_event_t       last_q;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

   // Accept handshakes; a full FIFO still takes a push when a pop frees a slot.
   always_comb begin
      do_pop  = pop_i & ~empty_o;
      do_push = push_i & (~full_o | do_pop);
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage array write port.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointers, occupancy and the last-popped holding register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         count_q <= count_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            last_q   <= mem_q[rd_ptr_q];
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise and debounce the bus, deframe 11-bit
// packets, fold E0/F0 prefixes into key events and queue them in a FIFO.
module ps2_kbd_rx
   import ps2_pkg::*;
#(
   parameter int unsigned DEB_BITS       = 3,
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [7:0]       ev_code,
   output logic             ev_ext,
   output logic             ev_brk,
   output logic [CNT_W-1:0] fifo_count,
   output logic             overflow,
   input  logic             ovf_clr,
   output logic             frame_err
);

   localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic                ps2c_meta_q, ps2c_sync_q, ps2d_meta_q, ps2d_sync_q;
   logic                deb_clk_q, deb_prev_q;
   logic [DEB_BITS-1:0] deb_cnt_q;
   logic                fall_edge;

   ps2_rx_state_e       state_q;
   logic [3:0]          bit_cnt_q;
   logic [7:0]          shift_q;
   logic                par_q, par_err_q;
   logic [WD_W-1:0]     wdog_q;
   logic                ext_q, brk_q;
   logic                frame_err_q;
   logic                overflow_q;

   logic                push, fifo_full, fifo_empty;
   ps2_event_t          push_ev, head_ev;

   // Two-flop synchronisers; the idle bus is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps2c_meta_q <= 1'b1;
         ps2c_sync_q <= 1'b1;
         ps2d_meta_q <= 1'b1;
         ps2d_sync_q <= 1'b1;
      end else begin
         ps2c_meta_q <= ps2_clk;
         ps2c_sync_q <= ps2c_meta_q;
         ps2d_meta_q <= ps2_data;
         ps2d_sync_q <= ps2d_meta_q;
      end
   end

   // Clock debouncer: follow the line after 2^DEB_BITS consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_clk_q  <= 1'b1;
         deb_prev_q <= 1'b1;
         deb_cnt_q  <= '0;
      end else begin
         deb_prev_q <= deb_clk_q;
         if (ps2c_sync_q == deb_clk_q) begin
            deb_cnt_q <= '0;
         end else if (deb_cnt_q == '1) begin
            deb_clk_q <= ps2c_sync_q;
            deb_cnt_q <= '0;
         end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
         end
      end
   end

   assign fall_edge = deb_prev_q & ~deb_clk_q;

   // Frame deframer, prefix tracking and inter-edge watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RX_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b1;
         par_err_q   <= 1'b0;
         wdog_q      <= '0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (fall_edge && !ps2d_sync_q) begin
                  state_q   <= RX_RECV;
                  bit_cnt_q <= '0;
                  par_q     <= 1'b1;
                  par_err_q <= 1'b0;
                  wdog_q    <= '0;
               end
            end
            RX_RECV: begin
               if (fall_edge) begin
                  wdog_q <= '0;
                  if (bit_cnt_q < 4'd8) begin
                     shift_q   <= {ps2d_sync_q, shift_q[7:1]};
                     par_q     <= par_q ^ ps2d_sync_q;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end else if (bit_cnt_q == 4'd8) begin
                     par_err_q <= (ps2d_sync_q != par_q);
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end else begin
                     state_q   <= RX_IDLE;
                     bit_cnt_q <= '0;
                     if (par_err_q || !ps2d_sync_q) begin
                        frame_err_q <= 1'b1;
                        ext_q       <= 1'b0;
                        brk_q       <= 1'b0;
                     end else if (shift_q == PS2_PFX_EXT) begin
                        ext_q <= 1'b1;
                     end else if (shift_q == PS2_PFX_BRK) begin
                        brk_q <= 1'b1;
                     end else begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                     end
                  end
               end else if (wdog_q == WD_LAST) begin
                  state_q     <= RX_IDLE;
                  bit_cnt_q   <= '0;
                  frame_err_q <= 1'b1;
                  ext_q       <= 1'b0;
                  brk_q       <= 1'b0;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

   // Push is decoded in the stop-edge cycle so the entry lands at the end of it.
   always_comb begin
      push = (state_q == RX_RECV) && fall_edge && (bit_cnt_q == 4'd9) &&
             ps2d_sync_q && !par_err_q &&
             (shift_q != PS2_PFX_EXT) && (shift_q != PS2_PFX_BRK);
      push_ev.ext  = ext_q;
      push_ev.brk  = brk_q;
      push_ev.code = shift_q;
   end

   // Sticky overflow: a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (push && fifo_full && !ev_ready) begin
         overflow_q <= 1'b1;
      end else if (ovf_clr) begin
         overflow_q <= 1'b0;
      end
   end

   ps2_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .push_i  (push),
      .data_i  (push_ev),
      .pop_i   (ev_ready),
      .data_o  (head_ev),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign ev_valid  = ~fifo_empty;
   assign ev_code   = head_ev.code;
   assign ev_ext    = head_ev.ext;
   assign ev_brk    = head_ev.brk;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver. Synchronises and debounces ps2_clk/ps2_data, deframes 11-bit packets (start, 8 data LSB-first, odd parity, stop) and folds E0/F0 prefixes into structured key events. Events are buffered in a FIFO with a valid/ready output port. Adds an inter-edge timeout watchdog, error reporting and overflow tracking. Feeds the display and host logic in place of a raw two-byte scan-code register.

Parameters:
DEB_BITS, 3, debounced ps2_clk changes only after 2^DEB_BITS consecutive equal synchronised samples
TIMEOUT_CYCLES, 10000, max clk cycles between debounced falling edges inside a frame before abort
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock from keyboard
ps2_data  in  1  raw PS/2 data from keyboard
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head; pop when ev_valid&ev_ready
ev_code  out  8  scan code of head event
ev_ext  out  1  head event was prefixed by E0
ev_brk  out  1  head event was prefixed by F0 (key release)
fifo_count  out  CNT_W  entries currently stored
overflow  out  1  sticky: event dropped because FIFO full
ovf_clr  in  1  synchronous clear of overflow
frame_err  out  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Reset (async, rst_n=0): sync flops and debounced clk = 1 (bus idle high), debounce counter 0, state IDLE, bit counter 0, prefix flags 0, FIFO empty; ev_valid=0, ev_code=0, ev_ext=0, ev_brk=0, fifo_count=0, overflow=0, frame_err=0. Reset mid-frame discards the partial frame.
- Input path: 2-flop synchroniser on both inputs. Debouncer applies to clk line only. Falling edge = debounced clk 1->0 versus previous-cycle value. Data is sampled from the synchronised data line in the edge cycle.
- FSM states:
  - IDLE: on edge with data=0 (start), go RECV, bit cnt=0, parity acc=1, watchdog=0. Edge with data=1 is ignored; stay IDLE.
  - RECV: each edge shifts data in. cnt 0..7 = data bits, XOR into parity. cnt 8 = parity, error if bit != acc. cnt 9 = stop, error if 0. After the stop edge, go IDLE.
- Watchdog runs in RECV only and resets on every edge. At TIMEOUT_CYCLES without an edge: abort to IDLE, pulse frame_err, clear prefix flags.
- Frame error (parity/stop): pulse frame_err in the cycle after the stop edge. Discard byte, clear prefix flags, push nothing.
- Good frame, byte E0: set ext flag, no push. Byte F0: set brk flag, no push. Any other byte: push {ext,brk,code}, then clear both flags. E0 F0 xx yields ext=1, brk=1. Repeated identical codes are all pushed (no dedupe).
- Push latency: stop edge detected in cycle E; entry written at end of E; ev_valid=1 from cycle E+1. No bypass.
- FIFO: show-ahead; ev_* reflect head while ev_valid=1; outputs hold their last value when empty.
  - Pop when ev_valid&ev_ready.
  - Full and push without pop: drop the event, set overflow.
  - Full with simultaneous push and pop: both succeed, count unchanged.
  - Empty with ev_ready=1: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: stays set until ovf_clr=1. If a drop and ovf_clr occur in the same cycle, set wins.

Decomposition:
- Package ps2_pkg: ps2_event_t packed struct {ext, brk, code[7:0]}; localparams PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0; rx state enum {RX_IDLE, RX_RECV}.
- Sub-module ps2_event_fifo: synchronous FIFO of ps2_event_t, parameter DEPTH, with push, pop, full, empty and count.
- Synchroniser, debouncer, FSM and watchdog live in ps2_kbd_rx.

Test Plan:
- DEB_BITS=2, send frame 0x1C with correct parity -> ev_valid=1 one cycle after stop edge; ev_code=1C, ev_ext=0, ev_brk=0, fifo_count=1.
- Send F0,1C then E0,F0,75 -> two events: {0,1,1C} and {1,1,75}; no events for prefixes.
- Send 0x1C with parity flipped, then 0x32 -> one frame_err pulse; FIFO holds only 32. Same with stop=0.
- TIMEOUT_CYCLES=200, stall clk after 4 bits, then send 0x2A -> frame_err pulse at cycle 200; FIFO holds only 2A. Also: E0, timeout, 0x2A yields ext=0.
- FIFO_DEPTH=4, ev_ready=0, send 5 codes 01..05 -> count=4, overflow=1, 05 dropped. Drain gives 01..04. Pulse ovf_clr -> overflow=0.
- FIFO full with ev_ready=1 held while the next push lands -> count stays 4, order preserved. Assert rst_n mid-frame -> all outputs at reset values, next full frame received cleanly.
